// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_ctrl_pkg: width codes, FSM encoding and legality check.       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Unknown width code, or an access not naturally aligned to its size.
  function automatic logic is_illegal(input logic store, input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic bad_code;
    logic bad_align;
    if (store) begin
      bad_code = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
    end else begin
      bad_code = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                   funct3 == F3_LBU || funct3 == F3_LHU);
    end
    case (funct3[1:0])
      2'b01:   bad_align = off[0];
      2'b10:   bad_align = (off != 2'b00);
      default: bad_align = 1'b0;
    endcase
    return bad_code | bad_align;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_load_align_ext.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_align_ext: moves the addressed lane down and extends it.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module load_align_ext
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {24'd0, shifted[7:0]};
      F3_LHU:  result = {16'd0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_ctrl: MEM-stage load/store sequencer over a req/gnt/rvalid bus|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic        flush,
  output logic        op_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        killed_q, killed_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] load_result;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  load_align_ext u_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

  always_comb begin
    case (op_funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << op_addr[1:0];
        wdata_new = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << op_addr[1:0];
        wdata_new = {2{op_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = op_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    killed_d     = killed_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (is_illegal(op_store, op_funct3, op_addr[1:0])) begin
            resp_err_d = 1'b1;
          end else begin
            state_d     = ST_REQ;
            store_d     = op_store;
            funct3_d    = op_funct3;
            off_d       = op_addr[1:0];
            killed_d    = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = op_store;
            mem_addr_d  = {op_addr[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
          killed_d  = flush;
        end else if (flush) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        // A flush arriving alongside the response still suppresses it.
        if (mem_rvalid) begin
          state_d  = ST_IDLE;
          killed_d = 1'b0;
          if (!(killed_q || flush)) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = store_q ? 32'd0 : load_result;
          end
        end else if (flush) begin
          killed_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      killed_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      killed_q     <= killed_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign op_ready   = (state_q == ST_IDLE);
  assign stall      = (op_valid & ~op_ready) | (state_q != ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lsu_ctrl: directed and randomized checks against a lane model. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_store = 1'b0;
  logic [2:0]  op_funct3 = 3'd0;
  logic [31:0] op_addr = 32'd0;
  logic [31:0] op_wdata = 32'd0;
  logic        flush = 1'b0;
  logic        op_ready, stall, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int errors = 0;
  int checks = 0;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_store(op_store),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush),
    .op_ready(op_ready), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes, derived from the width code.
  function automatic int ref_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_legal(input bit st, input logic [2:0] f3, input logic [1:0] o);
    bit code_ok;
    if (st) code_ok = (f3 <= 3'd2);
    else    code_ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return code_ok && ((int'(o) % ref_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] o);
    int unsigned m;
    m = ((32'd1 << ref_size(f3)) - 1) << o;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    int sz;
    sz = ref_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] d);
    logic [31:0] v, mask;
    int sz;
    sz = ref_size(f3);
    v = d >> (8 * o);
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 1;
    v = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // Runs one op starting at a falling edge; returns at the falling edge where
  // resp_valid/resp_err is visible, so chained calls issue back-to-back.
  task automatic do_op(input string nm, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int gd, input int rvd);
    logic [31:0] exp_rd;
    exp_rd = st ? 32'd0 : ref_load(f3, addr[1:0], rd);
    op_valid = 1'b1; op_store = st; op_funct3 = f3; op_addr = addr; op_wdata = wd;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_at_issue: got %b want 1", nm, op_ready);
    end
    @(negedge clk);
    op_valid = 1'b0;
    if (!ref_legal(st, f3, addr[1:0])) begin
      checks++;
      if (resp_err !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0 || op_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s err_pulse: got err=%b req=%b rv=%b rdy=%b want 1 0 0 1",
                 nm, resp_err, mem_req, resp_valid, op_ready);
      end
      return;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== {addr[31:2], 2'b00} ||
        mem_be !== ref_be(f3, addr[1:0]) || (st && mem_wdata !== ref_wdata(f3, wd)) ||
        stall !== 1'b1 || op_ready !== 1'b0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s bus_fields: got req=%b we=%b addr=%h be=%b wd=%h stall=%b want 1 %b %h %b %h 1",
               nm, mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, st,
               {addr[31:2], 2'b00}, ref_be(f3, addr[1:0]), ref_wdata(f3, wd));
    end
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1) begin
        errors++; $display("FAIL %s req_held: got %b want 1", nm, mem_req);
      end
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL %s after_gnt: got req=%b stall=%b want 0 1", nm, mem_req, stall);
    end
    for (int i = 0; i < rvd; i++) @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || op_ready !== 1'b1 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s response: got rv=%b data=%h rdy=%b want 1 %h 1",
               nm, resp_valid, resp_rdata, op_ready, exp_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_be !== 0 || mem_wdata !== 0 ||
        resp_valid !== 0 || resp_err !== 0 || resp_rdata !== 0 || op_ready !== 1 || stall !== 0) begin
      errors++;
      $display("FAIL reset_state: got req=%b be=%b rv=%b err=%b rdy=%b stall=%b want 0 0 0 0 1 0",
               mem_req, mem_be, resp_valid, resp_err, op_ready, stall);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    do_op("lb_203", 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 0, 0);
    do_op("lbu_203", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 1, 2);
    do_op("sh_012", 1'b1, 3'b001, 32'h012, 32'h0000ABCD, 32'h1234_5678, 0, 1);
    do_op("lhu_002", 1'b0, 3'b101, 32'h002, 32'h0, 32'h8001_7FFF, 2, 0);
    do_op("sb_001", 1'b1, 3'b000, 32'h001, 32'h0000_00A5, 32'h0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back_errors();
    do_op("err_lh_001", 1'b0, 3'b001, 32'h001, 32'h0, 32'h0, 0, 0);
    do_op("err_sw_002", 1'b1, 3'b010, 32'h002, 32'h0, 32'h0, 0, 0);
    do_op("err_ld_011", 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0);
    do_op("err_sb_100", 1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++;
    if (resp_err !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL err_clear: got err=%b req=%b want 0 0", resp_err, mem_req);
    end
  endtask

  task automatic test_flush();
    bit seen;
    op_valid = 1'b1; op_store = 1'b0; op_funct3 = 3'b010; op_addr = 32'h40;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 0); mem_rvalid = (i == 1);
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    checks++;
    if (seen || op_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL flush_req: got seen=%b rdy=%b req=%b want 0 1 0", seen, op_ready, mem_req);
    end
    op_valid = 1'b1; op_addr = 32'h44;
    @(negedge clk);
    op_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL flush_wait: got rv=%b rdy=%b want 0 1", resp_valid, op_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    op_valid = 1'b1; op_store = 1'b0; op_funct3 = 3'b010; op_addr = 32'h80;
    @(negedge clk);
    op_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 0 || mem_addr !== 0 || mem_be !== 0 || resp_valid !== 0 || stall !== 0 || op_ready !== 1) begin
      errors++;
      $display("FAIL async_reset: got req=%b addr=%h be=%b stall=%b rdy=%b want 0 0 0 0 1",
               mem_req, mem_addr, mem_be, stall, op_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL stray_rvalid: got rv=%b want 0", resp_valid);
    end
    do_op("lw_after_rst", 1'b0, 3'b010, 32'h84, 32'h0, 32'h0BAD_F00D, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_op("rand", ($urandom % 2) == 1, 3'($urandom % 8), $urandom, $urandom, $urandom,
            int'($urandom % 4), int'($urandom % 4));
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back_errors();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
